// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receiver: FSM states, ASCII constants and
// the (length, pattern) -> ASCII decode table.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_EMIT,
        ST_WORDWAIT
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam int         CODE_W      = 7;

    typedef struct packed {
        logic       hit;
        logic [7:0] ch;
    } decode_t;

    // Pattern holds the first element at bit len-1, 1 = dash, upper bits zero.
    function automatic decode_t morse_decode(input logic [2:0] len, input logic [CODE_W-1:0] pat);
        decode_t r;
        r.hit = 1'b1;
        r.ch  = ASCII_QMARK;
        case ({len, pat})
            {3'd1, 7'b0000000}: r.ch = "E";
            {3'd1, 7'b0000001}: r.ch = "T";
            {3'd2, 7'b0000000}: r.ch = "I";
            {3'd2, 7'b0000001}: r.ch = "A";
            {3'd2, 7'b0000010}: r.ch = "N";
            {3'd2, 7'b0000011}: r.ch = "M";
            {3'd3, 7'b0000000}: r.ch = "S";
            {3'd3, 7'b0000001}: r.ch = "U";
            {3'd3, 7'b0000010}: r.ch = "R";
            {3'd3, 7'b0000011}: r.ch = "W";
            {3'd3, 7'b0000100}: r.ch = "D";
            {3'd3, 7'b0000101}: r.ch = "K";
            {3'd3, 7'b0000110}: r.ch = "G";
            {3'd3, 7'b0000111}: r.ch = "O";
            {3'd4, 7'b0000000}: r.ch = "H";
            {3'd4, 7'b0000001}: r.ch = "V";
            {3'd4, 7'b0000010}: r.ch = "F";
            {3'd4, 7'b0000100}: r.ch = "L";
            {3'd4, 7'b0000110}: r.ch = "P";
            {3'd4, 7'b0000111}: r.ch = "J";
            {3'd4, 7'b0001000}: r.ch = "B";
            {3'd4, 7'b0001001}: r.ch = "X";
            {3'd4, 7'b0001010}: r.ch = "C";
            {3'd4, 7'b0001011}: r.ch = "Y";
            {3'd4, 7'b0001100}: r.ch = "Z";
            {3'd4, 7'b0001101}: r.ch = "Q";
            {3'd5, 7'b0000000}: r.ch = "5";
            {3'd5, 7'b0000001}: r.ch = "4";
            {3'd5, 7'b0000011}: r.ch = "3";
            {3'd5, 7'b0000111}: r.ch = "2";
            {3'd5, 7'b0001111}: r.ch = "1";
            {3'd5, 7'b0010000}: r.ch = "6";
            {3'd5, 7'b0010001}: r.ch = "=";
            {3'd5, 7'b0010010}: r.ch = "/";
            {3'd5, 7'b0011000}: r.ch = "7";
            {3'd5, 7'b0011100}: r.ch = "8";
            {3'd5, 7'b0011110}: r.ch = "9";
            {3'd5, 7'b0011111}: r.ch = "0";
            {3'd6, 7'b0010101}: r.ch = ".";
            {3'd6, 7'b0110011}: r.ch = ",";
            {3'd6, 7'b0001100}: r.ch = "?";
            {3'd6, 7'b0100001}: r.ch = "-";
            default:            r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; emits the
// debounced level plus single-cycle rise/fall strobes aligned with it.
module morse_debounce #(
    parameter int DEBOUNCE_TICKS = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample equal to the current level restarts the stability count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/morse_rx.sv
// Morse receiver: debounced key -> mark/gap timing FSM -> decode -> small
// output FIFO presented as a registered valid/ready ASCII stream.
module morse_rx
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS     = 50000000,
    parameter int DASH_UNITS     = 2,
    parameter int LETTER_UNITS   = 2,
    parameter int WORD_UNITS     = 4,
    parameter int DEBOUNCE_TICKS = 500000,
    parameter int MAX_LEN        = 6,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMER_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       morse_in,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       button_pressed,
    output logic       char_error,
    output logic       overflow
);
    localparam logic [TIMER_W-1:0] DASH_T   = TIMER_W'(DASH_UNITS * UNIT_TICKS);
    localparam logic [TIMER_W-1:0] LETTER_T = TIMER_W'(LETTER_UNITS * UNIT_TICKS);
    localparam logic [TIMER_W-1:0] WORD_T   = TIMER_W'(WORD_UNITS * UNIT_TICKS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic k_level, k_rise, k_fall;

    morse_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (morse_in),
        .level (k_level),
        .rise  (k_rise),
        .fall  (k_fall)
    );

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic [MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [2:0]           len_q, len_d;
    logic                 err_q, err_d;
    logic                 pend_q, pend_d;
    logic                 char_error_q, char_error_d;
    logic                 overflow_q, overflow_d;
    logic                 push, bad;
    logic [7:0]           push_char;
    decode_t              dec;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [7:0]           out_char_q, out_char_d;
    logic                 out_valid_q, out_valid_d;
    logic                 full, pop, wr_en;

    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign dec       = morse_decode(len_q, CODE_W'(pattern_q));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc;
        pattern_d = pattern_q;
        len_d     = len_q;
        err_d     = err_q;
        pend_d    = 1'b0;
        push      = 1'b0;
        push_char = ASCII_SPACE;
        bad       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (k_rise) begin
                    state_d   = ST_MARK;
                    pattern_d = '0;
                    len_d     = '0;
                    err_d     = 1'b0;
                end
            end
            ST_MARK: begin
                if (k_fall) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                    if (len_q == 3'(MAX_LEN)) begin
                        err_d = 1'b1;
                    end else begin
                        pattern_d = {pattern_q[MAX_LEN-2:0], (timer_inc >= DASH_T)};
                        len_d     = len_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                // A rise on the threshold cycle is remembered and serviced in WORDWAIT.
                if (timer_inc >= LETTER_T) begin
                    state_d = ST_EMIT;
                    pend_d  = k_rise;
                end else if (k_rise) begin
                    state_d = ST_MARK;
                    timer_d = '0;
                end
            end
            ST_EMIT: begin
                push      = 1'b1;
                bad       = err_q | ~dec.hit;
                push_char = bad ? ASCII_QMARK : dec.ch;
                err_d     = 1'b0;
                pend_d    = pend_q | k_rise;
                state_d   = ST_WORDWAIT;
            end
            ST_WORDWAIT: begin
                if (k_rise || pend_q) begin
                    state_d   = ST_MARK;
                    timer_d   = '0;
                    pattern_d = '0;
                    len_d     = '0;
                end else if (timer_inc >= WORD_T) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop   = out_valid_q & out_ready;
    assign wr_en = push & ~full;

    // Head register tracks the entry that will be at rd_ptr after this cycle.
    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
        wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_valid_d  = (count_d != '0);
        out_char_d   = out_char_q;
        if (wr_en && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
            out_char_d = push_char;
        end else if (pop && (count_q > CNT_W'(1))) begin
            out_char_d = mem_q[rd_ptr_d];
        end
        char_error_d = bad;
        overflow_d   = overflow_q | (push & full);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_char;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            pattern_q    <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            pend_q       <= 1'b0;
            char_error_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_char_q   <= ASCII_SPACE;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            err_q        <= err_d;
            pend_q       <= pend_d;
            char_error_q <= char_error_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_char_q   <= out_char_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_char       = out_char_q;
    assign out_valid      = out_valid_q;
    assign button_pressed = k_level;
    assign char_error     = char_error_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_morse_rx.sv
// Self-checking bench for morse_rx: randomized key timings, expected text
// derived from a string-based Morse dictionary.
module tb_morse_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       morse_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_char;
    logic       out_valid, button_pressed, char_error, overflow;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [7:0] rx_q [$];

    string morse_tbl [42] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        ".-.-.-", "--..--", "..--..", "-..-.", "-...-", "-....-"};
    string chr_tbl = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/=-";

    morse_rx #(
        .UNIT_TICKS(10),
        .DEBOUNCE_TICKS(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .morse_in       (morse_in),
        .out_char       (out_char),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .button_pressed (button_pressed),
        .char_error     (char_error),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) rx_q.push_back(out_char);
            if (char_error) err_pulses++;
        end
    end

    function automatic logic [7:0] ref_char(input string code);
        if (code.len() > 6) return 8'h3F;
        foreach (morse_tbl[i]) begin
            if (morse_tbl[i] == code) return chr_tbl[i];
        end
        return 8'h3F;
    endfunction

    task automatic key(input logic lvl, input int n);
        morse_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_code(input string code, input int gap);
        for (int i = 0; i < code.len(); i++) begin
            key(1'b1, (code[i] == 8'h2D) ? int'($urandom_range(35, 26)) : int'($urandom_range(14, 5)));
            if (i != code.len() - 1) key(1'b0, int'($urandom_range(14, 5)));
        end
        key(1'b0, gap);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_char !== 8'h20) begin errors++; $display("FAIL reset_char got %h want 20", out_char); end
        checks++; if (button_pressed !== 1'b0) begin errors++; $display("FAIL reset_button got %b want 0", button_pressed); end
        checks++; if (char_error !== 1'b0) begin errors++; $display("FAIL reset_char_error got %b want 0", char_error); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        reset = 1'b0;
        key(1'b0, 5);
        $display("test_reset done");
    endtask

    task automatic test_letter_a();
        int base = rx_q.size();
        int n = 0;
        bit seen = 0;
        logic [7:0] exp [$] = '{8'h41, 8'h20};
        out_ready = 1'b1;
        key(1'b1, 10);
        key(1'b0, 10);
        key(1'b1, 25);
        morse_in = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (!button_pressed) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL a_fall got no debounced fall want fall within 20"); end
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 22) begin errors++; $display("FAIL a_latency got %0d want 22", n); end
        @(posedge clk);
        #1;
        key(1'b0, 60);
        checks++; if ((rx_q.size() - base) != exp.size()) begin errors++; $display("FAIL a_count got %0d want %0d", rx_q.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp[i]) begin
                errors++;
                $display("FAIL a_char[%0d] got %h want %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp[i]);
            end
        end
        $display("test_letter_a done, %0d chars", rx_q.size() - base);
    endtask

    task automatic test_sos();
        int base = rx_q.size();
        int ebase = err_pulses;
        logic [7:0] exp [$] = '{8'h53, 8'h4F, 8'h53, 8'h20};
        out_ready = 1'b1;
        send_code("...", 30);
        send_code("---", 30);
        send_code("...", 55);
        checks++; if ((rx_q.size() - base) != exp.size()) begin errors++; $display("FAIL sos_count got %0d want %0d", rx_q.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp[i]) begin
                errors++;
                $display("FAIL sos_char[%0d] got %h want %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (err_pulses != ebase) begin errors++; $display("FAIL sos_char_error got %0d pulses want 0", err_pulses - ebase); end
        $display("test_sos done");
    endtask

    task automatic test_errors();
        int base = rx_q.size();
        int ebase = err_pulses;
        logic [7:0] exp [$];
        out_ready = 1'b1;
        send_code(".......", 25);
        key(1'b0, 30);
        send_code("..--", 55);
        exp = '{ref_char("......."), 8'h20, ref_char("..--"), 8'h20};
        checks++; if ((rx_q.size() - base) != exp.size()) begin errors++; $display("FAIL err_count got %0d want %0d", rx_q.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp[i]) begin
                errors++;
                $display("FAIL err_char[%0d] got %h want %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (err_pulses - ebase != 2) begin errors++; $display("FAIL err_pulses got %0d want 2", err_pulses - ebase); end
        $display("test_errors done");
    endtask

    task automatic test_random();
        int base = rx_q.size();
        int ebase = err_pulses;
        string codes [$];
        logic [7:0] exp [$];
        codes.push_back(".-.-.-");
        codes.push_back("-....-");
        for (int i = 0; i < 6; i++) codes.push_back(morse_tbl[$urandom_range(41, 0)]);
        out_ready = 1'b1;
        foreach (codes[i]) begin
            send_code(codes[i], (i == codes.size() - 1) ? 55 : int'($urandom_range(35, 25)));
            exp.push_back(ref_char(codes[i]));
        end
        exp.push_back(8'h20);
        checks++; if ((rx_q.size() - base) != exp.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", rx_q.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp[i]) begin
                errors++;
                $display("FAIL rand_char[%0d] got %h want %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (err_pulses != ebase) begin errors++; $display("FAIL rand_char_error got %0d pulses want 0", err_pulses - ebase); end
        $display("test_random done, %0d codes", codes.size());
    endtask

    task automatic test_glitch();
        int base = rx_q.size();
        bit btn_seen = 0;
        bit vld_seen = 0;
        out_ready = 1'b1;
        key(1'b1, 1);
        morse_in = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (button_pressed) btn_seen = 1;
            if (out_valid) vld_seen = 1;
        end
        @(posedge clk);
        #1;
        checks++; if (btn_seen) begin errors++; $display("FAIL glitch_button got 1 want 0"); end
        checks++; if (vld_seen) begin errors++; $display("FAIL glitch_valid got 1 want 0"); end
        checks++; if (rx_q.size() != base) begin errors++; $display("FAIL glitch_chars got %0d want 0", rx_q.size() - base); end
        $display("test_glitch done");
    endtask

    task automatic test_backpressure();
        int base = rx_q.size();
        logic [7:0] letters [5];
        logic [7:0] exp [$];
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int idx = int'($urandom_range(25, 0));
            letters[i] = ref_char(morse_tbl[idx]);
            send_code(morse_tbl[idx], 55);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_char !== letters[0]) begin errors++; $display("FAIL bp_stable[%0d] got %h want %h", i, out_char, letters[0]); end
            checks++; if (overflow !== (i >= 2)) begin errors++; $display("FAIL bp_overflow[%0d] got %b want %b", i, overflow, (i >= 2)); end
        end
        exp = '{letters[0], 8'h20, letters[1], 8'h20};
        out_ready = 1'b1;
        key(1'b0, 10);
        checks++; if ((rx_q.size() - base) != exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", rx_q.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_char[%0d] got %h want %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        int base;
        out_ready = 1'b0;
        send_code(".", 55);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_prefill got %b want 1", out_valid); end
        key(1'b1, 15);
        reset = 1'b1;
        morse_in = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", out_valid); end
        checks++; if (out_char !== 8'h20) begin errors++; $display("FAIL rm_char got %h want 20", out_char); end
        checks++; if (button_pressed !== 1'b0) begin errors++; $display("FAIL rm_button got %b want 0", button_pressed); end
        checks++; if (char_error !== 1'b0) begin errors++; $display("FAIL rm_char_error got %b want 0", char_error); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow got %b want 0", overflow); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        base = rx_q.size();
        out_ready = 1'b1;
        key(1'b0, 80);
        checks++; if (rx_q.size() != base) begin errors++; $display("FAIL rm_chars got %0d want 0", rx_q.size() - base); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_idle_valid got %b want 0", out_valid); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_sos();
        test_errors();
        test_random();
        test_glitch();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_rx.md
Name: morse_rx

Overview:
Parametrised next-generation Morse receiver. A single key input feeds a synchroniser, a debouncer, a mark/gap timing FSM and a decode table; decoded characters pass through a small FIFO to a valid/ready ASCII stream. Adds the following to the first-generation decoder: word-space output, punctuation decoding, a configurable time unit and code length, backpressure, and error/overflow reporting. It sits between the key/button pin logic and the display/UART character consumer.

Parameters:
UNIT_TICKS, 50000000, clock cycles per Morse dot unit.
DASH_UNITS, 2, a mark of at least DASH_UNITS*UNIT_TICKS cycles is a dash; shorter is a dot.
LETTER_UNITS, 2, a gap of at least this many units ends a character.
WORD_UNITS, 4, a gap of at least this many units (counted from the start of the gap) ends a word.
DEBOUNCE_TICKS, 500000, number of consecutive stable cycles required before the debounced level changes.
MAX_LEN, 6, maximum number of elements per character; range 5..7.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2.
TIMER_W, 32, width of the mark/gap timers.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
morse_in  in  1  raw key level (1 = key down), asynchronous to clk
out_char  out  8  ASCII character at the FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_char when out_valid and out_ready are both high
button_pressed  out  1  debounced key level
char_error  out  1  one-cycle pulse when an unknown or over-length code is emitted as '?'
overflow  out  1  sticky flag: a character was dropped because the FIFO was full; cleared only by reset

Behaviour:
- Reset (async, active-high): FSM to IDLE; timers, pattern and length cleared; FIFO emptied; out_valid=0, out_char=8'h20, button_pressed=0, char_error=0, overflow=0; synchroniser and debouncer flops cleared to 0.
- Input conditioning: 2-flop synchroniser, then debounce. The debounced level k follows the synchronised input after DEBOUNCE_TICKS consecutive equal samples. button_pressed=k. The FSM sees rise/fall edges of k only.
- Timers saturate at all-ones; they never wrap.
- Pattern encoding: pattern[MAX_LEN-1:0], with each new element shifted in at the LSB (1=dash, 0=dot); len counts the elements. The first element therefore sits at bit len-1.
- FSM states:
  - IDLE: waits for a rise of k and enters MARK with pattern=0, len=0, timer=0.
  - MARK: timer increments each cycle. On a fall of k, classify the mark as dot or dash and shift it in. If len was already MAX_LEN, set the internal error bit; pattern is held, len saturates. Go to GAP with timer=0.
  - GAP: timer increments each cycle.
    - A rise of k before LETTER_UNITS*UNIT_TICKS goes to MARK with timer=0.
    - Reaching LETTER_UNITS*UNIT_TICKS goes to EMIT.
    - If a rise of k and the threshold fall on the same cycle, the threshold wins: the character is emitted and the rise is handled from WORDWAIT.
  - EMIT (1 cycle): look up the code and push it to the FIFO.
    - An unknown code, or the error bit set, pushes '?' and pulses char_error.
    - Clears the error bit and goes to WORDWAIT; the gap timer keeps counting.
  - WORDWAIT: a rise of k goes to MARK with pattern/len cleared and no space emitted. Reaching WORD_UNITS*UNIT_TICKS pushes 8'h20 (once) and goes to IDLE.
- Decode table, by (len, pattern):
  - Letters A–Z and digits 0–9 in standard ITU Morse.
  - Punctuation: '.' .-.-.-, ',' --..--, '?' ..--.., '/' -..-., '=' -...-, '-' -....-
  - Any other code is unknown.
- FIFO:
  - A push and a pop in the same cycle are both honoured.
  - A push while full drops the new character and sets overflow; char_error still pulses if applicable.
  - out_char and out_valid are registered. The first push into an empty FIFO gives out_valid=1 on the next cycle.
  - out_char is stable while out_valid=1 and out_ready=0.
- Latency: fall of k → EMIT after LETTER_UNITS*UNIT_TICKS+1 cycles; out_valid one cycle after EMIT.
- Reset mid-character discards all state; no partial character is emitted.

Decomposition:
- Package morse_pkg:
  - FSM state encoding.
  - ASCII constants: space 8'h20 and '?' 8'h3F.
  - decode function (len, pattern → ASCII, hit flag).
- Sub-module morse_debounce (synchroniser + debounce counter), parametrised by DEBOUNCE_TICKS. The FIFO stays inline.

Test Plan:
All scenarios use UNIT_TICKS=10, DEBOUNCE_TICKS=2, FIFO_DEPTH=4.
1. "A": mark 10, gap 10, mark 25, then idle 60 with out_ready=1 → exactly 8'h41 then 8'h20. The 8'h41 appears with out_valid 20+1+1 cycles after the last debounced fall.
2. "SOS" with 30-cycle letter gaps and out_ready=1 → 8'h53, 8'h4F, 8'h53, 8'h20; char_error stays 0.
3. Seven dots (MAX_LEN=6), then gap 25 → 8'h3F with a char_error pulse. Unknown code ..-- (len 4) → 8'h3F.
4. Punctuation .-.-.- → 8'h2E; -....- → 8'h2D.
5. out_ready=0 while sending 5 letters (each followed by a word gap) → first 4 FIFO entries retained, remaining pushes dropped, overflow=1. Then out_ready=1 → the 4 retained characters drain in order, out_char stable while stalled.
6. A 1-cycle glitch on morse_in → no change on button_pressed, no output. Reset asserted mid-MARK → all outputs at reset values and no character emitted after release.
